// File: rtl/attn_pkg.sv
// Shared sizing defaults and the drain FSM state type for the systolic output path.
package attn_pkg;
    localparam int N1           = 4;
    localparam int N2           = 4;
    localparam int DATA_W       = 32;
    localparam int MATRIXSIZE_W = 16;
    localparam int ADDR_W_C     = 12;
    localparam int NE           = N1 * N2;
    localparam int IDX_W        = (NE > 1) ? $clog2(NE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drn_state_t;
endpackage

// File: rtl/result_drain_if.sv
// C-matrix write port: one element per valid/ready handshake.
interface result_drain_if;
    import attn_pkg::*;

    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W_C-1:0] wr_addr;
    logic [DATA_W-1:0]   wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/c_addr_gen.sv
// Row-major C address for (tile row, tile col, i, j) built from running bases; no divide.
// Zero latency from registered state; advances once per accepted element.
module c_addr_gen
    import attn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_step,
    input  logic                    i_last,
    input  logic [MATRIXSIZE_W-1:0] i_m3,
    input  logic [MATRIXSIZE_W-1:0] i_m3dn2,
    output logic [ADDR_W_C-1:0]     o_addr
);
    localparam int J_W = (N2 > 1) ? $clog2(N2) : 1;

    logic [MATRIXSIZE_W-1:0] r_tc;
    logic [ADDR_W_C-1:0]     r_col;
    logic [ADDR_W_C-1:0]     r_tile_row;
    logic [ADDR_W_C-1:0]     r_row;
    logic [J_W-1:0]          r_j;
    logic [ADDR_W_C-1:0]     w_m3;
    logic [ADDR_W_C-1:0]     w_m3xn1;

    assign w_m3    = ADDR_W_C'(i_m3);
    assign w_m3xn1 = w_m3 * ADDR_W_C'(N1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tc       <= '0;
            r_col      <= '0;
            r_tile_row <= '0;
            r_row      <= '0;
            r_j        <= '0;
        end else if (i_clr) begin
            r_tc       <= '0;
            r_col      <= '0;
            r_tile_row <= '0;
            r_row      <= '0;
            r_j        <= '0;
        end else if (i_step) begin
            if (i_last) begin
                r_j <= '0;
                // Wrapping tc moves the tile-row base down by N1 rows of C.
                if ((r_tc + 1'b1) >= i_m3dn2) begin
                    r_tc       <= '0;
                    r_col      <= '0;
                    r_tile_row <= r_tile_row + w_m3xn1;
                    r_row      <= r_tile_row + w_m3xn1;
                end else begin
                    r_tc  <= r_tc + 1'b1;
                    r_col <= r_col + ADDR_W_C'(N2);
                    r_row <= r_tile_row;
                end
            end else if (r_j == J_W'(N2 - 1)) begin
                r_j   <= '0;
                r_row <= r_row + w_m3;
            end else begin
                r_j <= r_j + 1'b1;
            end
        end
    end

    assign o_addr = r_row + r_col + ADDR_W_C'(r_j);
endmodule

// File: rtl/result_drain.sv
// Captures PE accumulators on the init wavefront into a ping-pong tile buffer and streams tiles to C.
// IDLE->DRAIN costs 1 cycle, then one element per handshake; wr_ready low stalls with addr/data held, a tile arriving on a full bank is dropped.
module result_drain
    import attn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [MATRIXSIZE_W-1:0]  M3,
    input  logic [MATRIXSIZE_W-1:0]  M3dN2,
    input  logic [MATRIXSIZE_W-1:0]  M1xM3dN1xN2,
    input  logic [NE-1:0]            init,
    input  logic [NE*DATA_W-1:0]     acc_data,
    result_drain_if.master           wr,
    output logic                     done,
    output logic                     overflow
);
    logic [DATA_W-1:0]       r_bank [2][NE];
    logic [1:0]              r_full;
    logic [1:0]              w_full_nxt;
    logic                    r_cap_bank;
    logic                    r_drn_bank;
    logic                    r_drop;
    logic                    r_overflow;
    logic [MATRIXSIZE_W-1:0] r_cap_cnt;
    logic [MATRIXSIZE_W-1:0] r_drn_cnt;
    logic [IDX_W-1:0]        r_idx;
    drn_state_t              r_state;
    drn_state_t              w_state_nxt;
    logic                    w_cap_en;
    logic                    w_drop;
    logic                    w_cap_end;
    logic                    w_valid;
    logic                    w_hs;
    logic                    w_last;
    logic                    w_drn_fin;
    logic                    w_clr;
    logic [ADDR_W_C-1:0]     w_addr;

    assign w_cap_en  = rst && (r_state != DONE);
    // The decision for a tile is taken on its init[0] and held for the rest of its wavefront.
    assign w_drop    = init[0] ? r_full[r_cap_bank] : r_drop;
    assign w_cap_end = w_cap_en && init[NE-1] && !w_drop;
    assign w_valid   = (r_state == DRAIN);
    assign w_hs      = w_valid && wr.wr_ready;
    assign w_last    = (r_idx == IDX_W'(NE - 1));
    assign w_drn_fin = w_hs && w_last;
    assign w_clr     = w_drn_fin && (w_state_nxt == DONE);

    always_ff @(posedge clk) begin
        for (int k = 0; k < NE; k++) begin
            if (w_cap_en && init[k] && !w_drop)
                r_bank[r_cap_bank][k] <= acc_data[k*DATA_W +: DATA_W];
        end
    end

    // Set is applied after clear so a tile completing into the bank being freed survives.
    always_comb begin
        w_full_nxt = r_full;
        if (w_drn_fin) w_full_nxt[r_drn_bank] = 1'b0;
        if (w_cap_end) w_full_nxt[r_cap_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full     <= '0;
            r_cap_bank <= 1'b0;
            r_drn_bank <= 1'b0;
            r_drop     <= 1'b0;
            r_overflow <= 1'b0;
            r_cap_cnt  <= '0;
            r_drn_cnt  <= '0;
            r_idx      <= '0;
            r_state    <= IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_full  <= w_full_nxt;
            if (w_cap_en && init[0]) begin
                r_drop <= r_full[r_cap_bank];
                if (r_full[r_cap_bank]) r_overflow <= 1'b1;
            end
            if (w_cap_end) begin
                r_cap_bank <= ~r_cap_bank;
                r_cap_cnt  <= r_cap_cnt + 1'b1;
            end
            if (w_drn_fin) begin
                r_drn_bank <= ~r_drn_bank;
                r_drn_cnt  <= r_drn_cnt + 1'b1;
            end
            if (r_state != DRAIN)
                r_idx <= '0;
            else if (w_hs)
                r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (r_full[r_drn_bank]) w_state_nxt = DRAIN;
            DRAIN:   if (w_drn_fin)
                         w_state_nxt = ((r_drn_cnt + 1'b1) == M1xM3dN1xN2) ? DONE : IDLE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    c_addr_gen u_addr (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_step  (w_hs),
        .i_last  (w_last),
        .i_m3    (M3),
        .i_m3dn2 (M3dN2),
        .o_addr  (w_addr)
    );

    assign wr.wr_valid = w_valid;
    assign wr.wr_addr  = w_valid ? w_addr : '0;
    assign wr.wr_data  = w_valid ? r_bank[r_drn_bank][r_idx] : '0;
    assign done        = (r_state == DONE);
    assign overflow    = r_overflow;
endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench: expected C writes are queued as each tile wavefront is driven and popped per handshake.
module tb_result_drain;
    import attn_pkg::*;

    typedef struct packed {
        logic [ADDR_W_C-1:0] a;
        logic [DATA_W-1:0]   d;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [MATRIXSIZE_W-1:0] m3, m3dn2, total;
    logic [NE-1:0]           init;
    logic [NE*DATA_W-1:0]    acc;
    logic                    done, overflow;
    exp_t                    sb_q[$];
    int                      n_chk = 0;
    int                      n_err = 0;
    int                      n_hs  = 0;
    int                      rdy_mode = 0;
    int                      hs0;

    result_drain_if wr_if();

    result_drain dut (
        .clk         (clk),
        .rst         (rst),
        .M3          (m3),
        .M3dN2       (m3dn2),
        .M1xM3dN1xN2 (total),
        .init        (init),
        .acc_data    (acc),
        .wr          (wr_if),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        wr_if.wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       wr_if.wr_ready = 1'b1;
                1:       wr_if.wr_ready = ~wr_if.wr_ready;
                default: wr_if.wr_ready = 1'b0;
            endcase
        end
    end

    // Inputs change just after posedge, so a negedge sample sees what the next edge will act on.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && wr_if.wr_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_wr", 64'(wr_if.wr_addr), 64'hFFFF);
            end else begin
                e = sb_q[0];
                if (wr_if.wr_ready) begin
                    chk("wr_addr", 64'(wr_if.wr_addr), 64'(e.a));
                    chk("wr_data", 64'(wr_if.wr_data), 64'(e.d));
                    void'(sb_q.pop_front());
                    n_hs++;
                end else begin
                    chk("stall_addr", 64'(wr_if.wr_addr), 64'(e.a));
                    chk("stall_data", 64'(wr_if.wr_data), 64'(e.d));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_tile(input int t, input int vb, input bit push);
        exp_t e;
        int   tr, tc;
        if (push) begin
            tr = t / int'(m3dn2);
            tc = t % int'(m3dn2);
            for (int k = 0; k < NE; k++) begin
                e.a = ADDR_W_C'((tr * N1 + k / N2) * int'(m3) + tc * N2 + k % N2);
                e.d = DATA_W'(vb + k);
                sb_q.push_back(e);
            end
        end
        for (int c = 0; c < N1 + N2 - 1; c++) begin
            for (int k = 0; k < NE; k++) begin
                init[k] = ((k / N2 + k % N2) == c);
                acc[k*DATA_W +: DATA_W] = DATA_W'(vb + k);
            end
            @(posedge clk);
            #1;
        end
        init = '0;
    endtask

    task automatic send_tiles(input int n, input int gap, input int drop_t);
        for (int t = 0; t < n; t++) begin
            send_tile(t, 100 + 100 * t, t != drop_t);
            if (t < n - 1) idle(gap - (N1 + N2 - 1));
        end
    endtask

    task automatic wait_done(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        init = '0;
        acc  = '0;
        #1;
        chk("rst_valid", 64'(wr_if.wr_valid), 64'd0);
        chk("rst_addr", 64'(wr_if.wr_addr), 64'd0);
        chk("rst_data", 64'(wr_if.wr_data), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        idle(2);
        sb_q.delete();
        rst = 1'b1;
        hs0 = n_hs;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        m3 = 16'd8; m3dn2 = 16'd2; total = 16'd2;
        rdy_mode = 0;

        // Two tiles at full ready, then check that init is ignored after done.
        do_reset();
        send_tiles(2, 8, -1);
        wait_done("t1_done", 200);
        idle(2);
        chk("t1_hs", 64'(n_hs - hs0), 64'd32);
        chk("t1_q_empty", 64'(sb_q.size()), 64'd0);
        chk("t1_ovf", 64'(overflow), 64'd0);
        send_tile(0, 900, 1'b0);
        idle(5);
        chk("done_ignore_vld", 64'(wr_if.wr_valid), 64'd0);
        chk("done_ignore_ovf", 64'(overflow), 64'd0);
        chk("done_sticky", 64'(done), 64'd1);

        // Alternating ready.
        do_reset();
        rdy_mode = 1;
        send_tiles(2, 8, -1);
        wait_done("t2_done", 300);
        idle(2);
        chk("t2_hs", 64'(n_hs - hs0), 64'd32);
        chk("t2_q_empty", 64'(sb_q.size()), 64'd0);

        // Ready held low: third tile must be dropped.
        do_reset();
        rdy_mode = 2;
        send_tiles(3, 8, 2);
        idle(5);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_stall_vld", 64'(wr_if.wr_valid), 64'd1);
        chk("t3_no_hs", 64'(n_hs - hs0), 64'd0);
        rdy_mode = 0;
        wait_done("t3_done", 200);
        idle(2);
        chk("t3_hs", 64'(n_hs - hs0), 64'd32);
        chk("t3_q_empty", 64'(sb_q.size()), 64'd0);

        // Four tiles wrap the tile column into the second tile row.
        do_reset();
        total = 16'd4;
        send_tiles(4, 20, -1);
        wait_done("t4_done", 400);
        idle(2);
        chk("t4_hs", 64'(n_hs - hs0), 64'd64);
        chk("t4_q_empty", 64'(sb_q.size()), 64'd0);
        chk("t4_ovf", 64'(overflow), 64'd0);

        // Reset asserted mid-drain after five writes.
        do_reset();
        total = 16'd1;
        send_tile(0, 100, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (n_hs - hs0 == 5) break;
        end
        chk("t5_pre_hs", 64'(n_hs - hs0), 64'd5);
        @(posedge clk);
        #2;
        chk("t5_pre_vld", 64'(wr_if.wr_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("t5_async_vld", 64'(wr_if.wr_valid), 64'd0);
        do_reset();
        send_tile(0, 500, 1'b1);
        wait_done("t5_done", 200);
        idle(2);
        chk("t5_hs", 64'(n_hs - hs0), 64'd16);
        chk("t5_q_empty", 64'(sb_q.size()), 64'd0);

        // Tile end coincides with the previous tile's final handshake.
        do_reset();
        total = 16'd3;
        send_tiles(3, 17, -1);
        wait_done("t6_done", 300);
        idle(2);
        chk("t6_hs", 64'(n_hs - hs0), 64'd48);
        chk("t6_q_empty", 64'(sb_q.size()), 64'd0);
        chk("t6_ovf", 64'(overflow), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
